// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port SRAM between three requesters
//   (0 = pattern generator, 1 = capture, 2 = processing) using a
//   round-robin arbiter with a bounded hold time.
//
//   Parameters
//     MAX_HOLD    max consecutive GRANT cycles for a holder while another
//                 requester is pending (2..255)
//
//   Ports
//     clk         system clock, rising edge
//     reset       synchronous, active-high
//     req         per-requester access request
//     gnt         one-hot grant (registered)
//     rq_addr     per-requester word address
//     rq_wdata    per-requester write data
//     rq_wren     per-requester write strobe
//     rq_rden     per-requester read strobe
//     sram_addr   registered SRAM address
//     sram_wdata  registered SRAM write data
//     sram_wren   registered SRAM write enable
//     sram_rden   registered SRAM read enable
//     sram_rdata  SRAM read data, valid one cycle after sram_rden
//     rd_data     sram_rdata passed through to all requesters
//     rd_valid    one-hot, marks rd_data valid for the issuing requester
module sram_port_arbiter #(
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  output logic [2:0]       gnt,
  input  logic [2:0][17:0] rq_addr,
  input  logic [2:0][31:0] rq_wdata,
  input  logic [2:0]       rq_wren,
  input  logic [2:0]       rq_rden,
  output logic [17:0]      sram_addr,
  output logic [31:0]      sram_wdata,
  output logic             sram_wren,
  output logic             sram_rden,
  input  logic [31:0]      sram_rdata,
  output logic [31:0]      rd_data,
  output logic [2:0]       rd_valid
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_SWITCH
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ptr;
  logic [1:0]  w_ptr_nxt;
  logic [1:0]  r_holder;
  logic [1:0]  w_holder_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [2:0]  r_gnt;
  logic [2:0]  w_gnt_nxt;

  logic [1:0]  w_sel;
  logic        w_sel_vld;
  logic [2:0]  w_holder_oh;
  logic        w_holder_req;
  logic        w_others_req;
  logic [1:0]  w_ptr_after;
  logic        w_fwd;

  logic [17:0] r_sram_addr;
  logic [31:0] r_sram_wdata;
  logic        r_sram_wren;
  logic        r_sram_rden;
  logic [2:0]  r_rd_src;
  logic [2:0]  r_rd_valid;

  // (p + k) mod 3 for p, k in 0..2
  function automatic logic [1:0] wrap3(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Round-robin scan: first asserted req starting at ptr.
  always_comb begin
    w_sel     = '0;
    w_sel_vld = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!w_sel_vld && req[wrap3(r_ptr, 2'(k))]) begin
        w_sel     = wrap3(r_ptr, 2'(k));
        w_sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_holder_oh  = 3'b001 << r_holder;
    w_holder_req = |(req & w_holder_oh);
    w_others_req = |(req & ~w_holder_oh);
    w_ptr_after  = wrap3(r_holder, 2'd1);
  end

  // Next-state / grant decode
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_holder_nxt = r_holder;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    w_fwd        = 1'b0;
    case (r_state)
      S_IDLE, S_SWITCH: begin
        if (w_sel_vld) begin
          w_state_nxt  = S_GRANT;
          w_gnt_nxt    = 3'b001 << w_sel;
          w_holder_nxt = w_sel;
          w_cnt_nxt    = '0;
        end else begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
        end
      end
      S_GRANT: begin
        if (!w_holder_req) begin
          // Holder released: its strobes this cycle are dropped.
          w_state_nxt = S_SWITCH;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = w_ptr_after;
        end else begin
          w_fwd = 1'b1;
          if (r_cnt == HOLD_LAST) begin
            // Counter parks at the limit until someone else asks.
            if (w_others_req) begin
              w_state_nxt = S_SWITCH;
              w_gnt_nxt   = '0;
              w_ptr_nxt   = w_ptr_after;
            end
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_holder <= '0;
      r_cnt    <= '0;
      r_gnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_holder <= w_holder_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gnt    <= w_gnt_nxt;
    end
  end

  // SRAM command path and read-return tagging
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_sram_wren  <= 1'b0;
      r_sram_rden  <= 1'b0;
      r_rd_src     <= '0;
      r_rd_valid   <= '0;
    end else begin
      // Write wins over a simultaneous read.
      r_sram_wren <= w_fwd & rq_wren[r_holder];
      r_sram_rden <= w_fwd & rq_rden[r_holder] & ~rq_wren[r_holder];
      if (w_fwd && (rq_wren[r_holder] || rq_rden[r_holder])) begin
        r_sram_addr  <= rq_addr[r_holder];
        r_sram_wdata <= rq_wdata[r_holder];
      end
      if (w_fwd && rq_rden[r_holder] && !rq_wren[r_holder]) begin
        r_rd_src <= w_holder_oh;
      end
      // Tag travels with the read so it survives a grant change.
      r_rd_valid <= r_sram_rden ? r_rd_src : '0;
    end
  end

  assign gnt        = r_gnt;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_wren  = r_sram_wren;
  assign sram_rden  = r_sram_rden;
  assign rd_data    = sram_rdata;
  assign rd_valid   = r_rd_valid;

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 64: maximum consecutive GRANT cycles for a holder while another requester is pending (range 2..255).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  input  3  per-requester access request (0 = pattern generator, 1 = capture, 2 = processing).
REQ-005 SHALL have port gnt  output  3  one-hot grant; registered.
REQ-006 SHALL have port rq_addr  input  3x18  per-requester word address.
REQ-007 SHALL have port rq_wdata  input  3x32  per-requester write data.
REQ-008 SHALL have port rq_wren  input  3  per-requester write strobe.
REQ-009 SHALL have port rq_rden  input  3  per-requester read strobe.
REQ-010 SHALL have port sram_addr  output  18  registered SRAM address.
REQ-011 SHALL have port sram_wdata  output  32  registered SRAM write data.
REQ-012 SHALL have port sram_wren  output  1  registered SRAM write enable.
REQ-013 SHALL have port sram_rden  output  1  registered SRAM read enable.
REQ-014 SHALL have port sram_rdata  input  32  SRAM read data, valid one cycle after sram_rden.
REQ-015 SHALL have port rd_data  output  32  sram_rdata passed through combinationally to all requesters.
REQ-016 SHALL have port rd_valid  output  3  one-hot; marks rd_data valid for the requester that issued the read.

Function
REQ-017 SHALL implement states IDLE, GRANT, SWITCH and a 2-bit round-robin pointer ptr (values 0..2).
REQ-018 Arbitration SHALL select the first asserted req scanning ptr, ptr+1, ptr+2 (mod 3).
REQ-019 IDLE: any req asserted -> GRANT with gnt one-hot on the selected requester at the next edge (req-to-gnt latency 1 cycle); no req -> stay IDLE, gnt=0.
REQ-020 GRANT: each cycle, sram_addr/sram_wdata/sram_wren/sram_rden SHALL register the holder's rq_addr/rq_wdata/rq_wren/rq_rden (1-cycle latency).
REQ-021 GRANT: holder's req low -> SWITCH; that cycle's holder strobes are ignored and sram_wren/sram_rden = 0.
REQ-022 GRANT: hold counter SHALL count GRANT cycles from 0; at count MAX_HOLD-1 with another req pending -> SWITCH (preemption); that cycle's strobes are still forwarded.
REQ-023 Hold counter SHALL not saturate-trigger while no other req is pending; it holds at MAX_HOLD-1 and clears on entry to GRANT.
REQ-024 On leaving GRANT, ptr SHALL become (holder+1) mod 3.
REQ-025 SWITCH SHALL last exactly 1 cycle with gnt=0, sram_wren=0, sram_rden=0; then arbitrate as in IDLE: grant next edge, or IDLE if no req.
REQ-026 Non-granted requesters' addr/data/strobes SHALL have no effect on SRAM outputs.
REQ-027 Holder asserting rq_wren and rq_rden together: write SHALL win, sram_rden=0.
REQ-028 sram_addr and sram_wdata SHALL hold their last value when strobes are 0.
REQ-029 rd_valid SHALL assert for exactly one cycle, one cycle after sram_rden, on the issuing requester's bit, even if the grant has since moved.
REQ-030 gnt SHALL never have more than one bit set; gnt and sram strobes SHALL never reference two requesters in one cycle.

Reset
REQ-031 With reset high at an edge: state=IDLE, ptr=0, hold counter=0, gnt=0, sram_addr=0, sram_wdata=0, sram_wren=0, sram_rden=0, rd_valid=0.
REQ-032 Reset mid-GRANT SHALL abort the grant and drop any in-flight rd_valid; reset has priority over all transitions.

Verification
REQ-033 req=3'b001 in IDLE at cycle t -> gnt=3'b001 at t+1; rq_wren[0]=1, rq_addr[0]=18'h00010, rq_wdata[0]=32'h00C0C0C0 at t+1 -> sram_wren=1 with those values at t+2.
REQ-034 req=3'b111 simultaneously from reset -> grants in order 0,1,2, each separated by exactly one SWITCH cycle with gnt=0 and sram_wren=0.
REQ-035 req[0] held continuously, req[1] raised during grant, MAX_HOLD=4 -> gnt[0] for exactly 4 cycles, 1 SWITCH cycle, then gnt=3'b010.
REQ-036 Holder 2 read at rq_addr=18'h3FFFF -> sram_rden=1 one cycle later, rd_valid=3'b100 the cycle after that; holder drops req meanwhile -> rd_valid still delivered.
REQ-037 Non-holder drives rq_wren=1 throughout -> sram_wren never reflects it; holder with rq_wren=rq_rden=1 -> sram_wren=1, sram_rden=0.
REQ-038 reset asserted during GRANT with a read outstanding -> next edge all outputs 0, rd_valid=0, IDLE, ptr=0.
